fifo_rr_wr_arb: RTL and testbench
=================================

# fifo_rr_wr_arb

Round-robin write-port arbiter that shares the single write port of the team's synchronous FIFO among NREQ independent producers. Each producer issues words with a req/ack handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `wr`/`data` inputs. It honours FIFO `full` backpressure so that no word is dropped or duplicated.

## Interface
- `WIDTH`, 8, data word width; equals the FIFO `WIDTH`.
- `NREQ`, 4, number of producers; range 2..8.
- `MAX_BURST`, 4, maximum words per grant; power of two, range 1..16.
- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  NREQ  per-producer request; high means the word on its `req_data` slice is valid.
- `req_data`  in  NREQ*WIDTH  producer words; producer i uses bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-hot, combinational; high means producer i's word is written this cycle.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr`  out  1  FIFO write request; combinational.
- `fifo_data`  out  WIDTH  FIFO write data; combinational mux of the granted slice.
- `grant`  out  NREQ  one-hot registered owner; all zero when idle.
- `busy`  out  1  registered; high while in GRANT.

## Operation
- FSM has two states: IDLE and GRANT.
- **IDLE**
  - If `req` is nonzero, select the first requester strictly after `last` in circular order (`last`+1, … , wrapping back to `last`).
  - Register the selected requester into `grant`, clear `burst_cnt`, and go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT** (owner g)
  - Write condition: `fifo_wr` = `ack[g]` = `req[g] & ~fifo_full`. `fifo_data` = slice g.
  - On each write, `burst_cnt` increments.
  - Exit to IDLE and set `last` <= g when either:
    - a write occurs with `burst_cnt` == MAX_BURST-1, or
    - `req[g]` is low (checked before any write that cycle).
  - If `req[g]` is high and `fifo_full` is high, hold: no write, counter frozen, no timeout.
- All `ack` bits other than the owner's stay 0. A non-owner's `req` is ignored until it wins arbitration.
- Producer contract:
  - `req_data` is held stable while `req` is high.
  - The producer advances to its next word on the cycle after `ack`.
  - The producer may drop `req` only on a cycle after `ack`, or before it was ever granted.
- `burst_cnt` is clog2(MAX_BURST)+1 bits wide. For MAX_BURST == 1, every write exits.
- `last` is clog2(NREQ) bits; arithmetic is modulo NREQ. Non-power-of-two NREQ wraps explicitly to 0.
- Reset, asynchronous, mid-operation:
  - State goes to IDLE; `grant`, `busy`, and `burst_cnt` go to 0; `last` goes to NREQ-1, so producer 0 has first priority.
  - `fifo_wr` and `ack` drop to 0 immediately, combinationally, because the state is IDLE.

## Timing
- Reset values: `grant` = 0, `busy` = 0, `fifo_wr` = 0, `ack` = 0, `fifo_data` = slice 0 (don't-care).
- Arbitration latency: `req` rising in IDLE gives `grant`/`busy` on the next edge. The first write is possible in that following cycle.
- Re-arbitration costs 1 IDLE cycle between bursts. Peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle.
- `fifo_full` is sampled in the same cycle as `fifo_wr`. The FIFO's own `wr & ~full` gating is therefore never relied upon, and no write is issued when full.
- A write on cycle n appears in FIFO `usedw` at edge n+1.
- Starvation bound: a continuously requesting producer is granted within NREQ-1 bursts plus NREQ IDLE cycles, excluding `fifo_full` stalls.

## Structure
- Shared package `fifo_pkg` holds:
  - the `clog2` constant function (the same function the FIFO uses for `usedw`),
  - the FSM state encoding, with IDLE = 1'b0 and GRANT = 1'b1.
- One natural sub-module, `rr_pick`: combinational. Inputs are `req` and `last`; outputs are a one-hot `next` and `any`. It is reusable for the read-side scheduler.
- The top level instantiates `rr_pick` and holds the FSM, `burst_cnt`, `last`, and the output muxing.
- The bench connects the block to the existing 8x8 synchronous FIFO.

## Test plan
- **Reset and first grant:** after reset, assert `req` = 4'b1111 → `grant` = 4'b0001 on the next edge; producer 0 writes exactly 4 words; `grant` = 0 for 1 cycle, then 4'b0010.
- **Rotation and skip:** `req` = 4'b1010 held, `last` = 3 → grants 1, 3, 1, 3 …; each burst is 4 words; FIFO contents match per-producer order.
- **Early release:** producer 2 asserts `req` for 2 words only → 2 acks, then IDLE; `last` = 2; the next grant goes to the next active producer after 2.
- **Backpressure:** FIFO holds 7 words; owner writes 1 word → `fifo_full` = 1. Hold `full` for 5 cycles → `fifo_wr` = 0, `ack` = 0, `burst_cnt` frozen. Read 1 word from the FIFO → the write resumes the cycle after `full` drops; no loss and no duplicate.
- **Reset mid-burst:** `rst_n` low after the 2nd write of a burst → `fifo_wr`, `ack`, and `grant` go to 0 at once. After release with `req` = 4'b0100 → `grant` = 4'b0100 with a fresh 4-word burst.
- **Scoreboard soak:** NREQ = 3, MAX_BURST = 1, random `req` and random FIFO reads over 10k cycles → every acked word is read out exactly once, in per-producer order, and `fifo_wr` is never high while `full` is high.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO and the blocks that feed it.
//   clog2()              : ceil(log2(value)); the same sizing function the FIFO
//                          uses for its usedw counter.
//   ST_IDLE / ST_GRANT   : write-port arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

endpackage

// File: rtl/fifo_rr_wr_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans the requesters in circular order
// starting at the one strictly after `last` and reports the first one found.
// Ports:
//   req  [NREQ-1:0] in  : request vector
//   last [LW-1:0]   in  : index of the most recently served requester
//   next [NREQ-1:0] out : one-hot winner (all zero when nothing requests)
//   any             out : at least one requester present
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] next,
  output logic            any
);

  always_comb begin
    logic [LW-1:0] idx;
    next = '0;
    any  = 1'b0;
    idx  = last;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap keeps non-power-of-two NREQ inside 0..NREQ-1.
      if (idx == LW'(NREQ - 1)) begin
        idx = '0;
      end else begin
        idx = idx + LW'(1);
      end
      if (!any && req[idx]) begin
        next[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_rr_wr_arb
// Shares the single FIFO write port among NREQ producers. One producer owns the
// port for a burst of at most MAX_BURST words; ownership rotates round-robin
// with one IDLE cycle between bursts. FIFO full is honoured in the same cycle,
// so no word is ever offered to a full FIFO.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req      [NREQ-1:0]        : per-producer word valid
//   req_data [NREQ*WIDTH-1:0]  : producer words, producer i at [i*WIDTH +: WIDTH]
//   ack      [NREQ-1:0]        : one-hot, combinational; word written this cycle
//   fifo_full                  : FIFO full flag
//   fifo_wr                    : FIFO write strobe (combinational)
//   fifo_data [WIDTH-1:0]      : FIFO write data (owner's slice)
//   grant    [NREQ-1:0]        : registered one-hot owner, zero when idle
//   busy                       : registered, high while a burst is granted
// -----------------------------------------------------------------------------
module fifo_rr_wr_arb
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int LW = clog2(NREQ);
  localparam int CW = clog2(MAX_BURST) + 1;

  logic            state_reg;
  logic [NREQ-1:0] grant_reg;
  logic            busy_reg;
  logic [CW-1:0]   burst_cnt_reg;
  logic [LW-1:0]   last_reg;
  logic [LW-1:0]   owner_reg;    // binary form of grant_reg, used for muxing

  logic [NREQ-1:0] pick_next;
  logic            pick_any;
  logic [LW-1:0]   pick_idx;
  logic            owner_req;
  logic            wr;
  logic            last_word;
  logic [WIDTH-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req),
    .last (last_reg),
    .next (pick_next),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_next[i]) begin
        pick_idx = LW'(i);
      end
    end
  end

  assign owner_req = req[owner_reg];
  // Full is checked here rather than relying on the FIFO's own gating.
  assign wr        = (state_reg == ST_GRANT) && owner_req && !fifo_full;
  assign last_word = (burst_cnt_reg == CW'(MAX_BURST - 1));

  assign fifo_wr   = wr;
  assign ack       = wr ? grant_reg : '0;
  assign fifo_data = slice[owner_reg];
  assign grant     = grant_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
      burst_cnt_reg <= '0;
      last_reg      <= LW'(NREQ - 1);   // producer 0 wins first
      owner_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            state_reg     <= ST_GRANT;
            grant_reg     <= pick_next;
            owner_reg     <= pick_idx;
            busy_reg      <= 1'b1;
            burst_cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          // A released request ends the burst even if the FIFO is full;
          // a full FIFO with request still high simply holds.
          if (!owner_req || (wr && last_word)) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            last_reg  <= owner_reg;
          end else if (wr) begin
            burst_cnt_reg <= burst_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_wr_arb
// Two arbiters: A (NREQ=4, MAX_BURST=4) for the directed scenarios and
// B (NREQ=3, MAX_BURST=1) for the random soak. Each drives an 8-deep FIFO
// model (a queue) whose reads are checked for per-producer word order.
// A cycle-level reference model predicts grant/busy/ack/wr from the
// arbitration rules using integer owner/count/last bookkeeping.
// -----------------------------------------------------------------------------
module tb_fifo_rr_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  req_a, ack_a, grant_a;
  logic [31:0] req_data_a;
  logic        fifo_full_a, fifo_wr_a, busy_a;
  logic [7:0]  fifo_data_a;

  logic [2:0]  req_b, ack_b, grant_b;
  logic [23:0] req_data_b;
  logic        fifo_full_b, fifo_wr_b, busy_b;
  logic [7:0]  fifo_data_b;

  fifo_rr_wr_arb #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(req_data_a), .ack(ack_a),
    .fifo_full(fifo_full_a), .fifo_wr(fifo_wr_a), .fifo_data(fifo_data_a),
    .grant(grant_a), .busy(busy_a)
  );

  fifo_rr_wr_arb #(.WIDTH(8), .NREQ(3), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(req_data_b), .ack(ack_b),
    .fifo_full(fifo_full_b), .fifo_wr(fifo_wr_b), .fifo_data(fifo_data_b),
    .grant(grant_b), .busy(busy_b)
  );

  logic       rd_a, rd_b, soak_on;
  logic [3:0] en_a;
  int         left_a [4];          // words left per producer, -1 = unlimited
  int         seq [2][4];          // next word index per producer
  int         rd_seq [2][4];       // next word index expected out of the FIFO
  logic [7:0] fq_a [$];
  logic [7:0] fq_b [$];
  int         m_state [2], m_owner [2], m_cnt [2], m_last [2];
  int         n_checks, n_pass;

  logic [3:0] s_ack_a;
  logic [2:0] s_ack_b;
  logic       s_wr_a, s_wr_b, s_full_a, s_full_b;
  logic [7:0] s_data_a, s_data_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference arbiter: returns this cycle's expected outputs and advances to
  // the state that follows the coming clock edge.
  task automatic model_eval(input int u, input int n, input int mb, input logic [7:0] rq,
                            input logic full, input logic rstn,
                            output logic [7:0] e_ack, output logic [7:0] e_grant,
                            output logic e_busy);
    e_ack   = '0;
    e_grant = '0;
    e_busy  = 1'b0;
    if (!rstn) begin
      m_state[u] = 0;
      m_cnt[u]   = 0;
      m_last[u]  = n - 1;
    end else if (m_state[u] == 0) begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (m_last[u] + k) % n;
        if (m_state[u] == 0 && rq[c]) begin
          m_state[u] = 1;
          m_owner[u] = c;
          m_cnt[u]   = 0;
        end
      end
    end else begin
      e_grant = 8'(1) << m_owner[u];
      e_busy  = 1'b1;
      if (!rq[m_owner[u]]) begin
        m_state[u] = 0;
        m_last[u]  = m_owner[u];
      end else if (!full) begin
        e_ack = e_grant;
        m_cnt[u]++;
        if (m_cnt[u] == mb) begin
          m_state[u] = 0;
          m_last[u]  = m_owner[u];
        end
      end
    end
  endtask

  // FIFO model edge: read the old head, then append the written word.
  task automatic fifo_edge(input int u, input logic wr, input logic full,
                           input logic [7:0] d, input logic rd);
    logic [7:0] w;
    logic       got;
    int         id;
    string      p;
    p   = (u == 0) ? "a" : "b";
    got = 1'b0;
    w   = '0;
    if (u == 0) begin
      if (rd && fq_a.size() > 0) begin w = fq_a.pop_front(); got = 1'b1; end
      if (wr) fq_a.push_back(d);
    end else begin
      if (rd && fq_b.size() > 0) begin w = fq_b.pop_front(); got = 1'b1; end
      if (wr) fq_b.push_back(d);
    end
    if (wr) check({p, "_wr_while_full"}, 32'(full), 32'(0));
    if (got) begin
      id = int'(w[7:6]);
      check({p, "_order"}, 32'(w[5:0]), 32'(rd_seq[u][id] % 64));
      rd_seq[u][id]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = en_a[i] && (left_a[i] != 0);
      req_data_a[i*8 +: 8] = {2'(i), 6'(seq[0][i])};
    end
    for (int i = 0; i < 3; i++) begin
      req_data_b[i*8 +: 8] = {2'(i), 6'(seq[1][i])};
    end
    fifo_full_a = (fq_a.size() >= 8);
    fifo_full_b = (fq_b.size() >= 8);
  endtask

  task automatic tick();
    logic [7:0] ea, eg;
    logic       eb;
    @(negedge clk);
    model_eval(0, 4, 4, {4'b0, req_a}, fifo_full_a, rst_n, ea, eg, eb);
    check("a_ack",   32'(ack_a),     32'(ea[3:0]));
    check("a_wr",    32'(fifo_wr_a), 32'(|ea));
    check("a_grant", 32'(grant_a),   32'(eg[3:0]));
    check("a_busy",  32'(busy_a),    32'(eb));
    model_eval(1, 3, 1, {5'b0, req_b}, fifo_full_b, rst_n, ea, eg, eb);
    check("b_ack",   32'(ack_b),     32'(ea[2:0]));
    check("b_wr",    32'(fifo_wr_b), 32'(|ea));
    check("b_grant", 32'(grant_b),   32'(eg[2:0]));
    check("b_busy",  32'(busy_b),    32'(eb));
    s_ack_a = ack_a; s_wr_a = fifo_wr_a; s_data_a = fifo_data_a; s_full_a = fifo_full_a;
    s_ack_b = ack_b; s_wr_b = fifo_wr_b; s_data_b = fifo_data_b; s_full_b = fifo_full_b;
    @(posedge clk);
    #1;
    fifo_edge(0, s_wr_a, s_full_a, s_data_a, rd_a);
    fifo_edge(1, s_wr_b, s_full_b, s_data_b, rd_b);
    for (int i = 0; i < 4; i++) begin
      if (s_ack_a[i]) begin
        seq[0][i]++;
        if (left_a[i] > 0) left_a[i]--;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (s_ack_b[i]) seq[1][i]++;
      // A producer holds its request until acked, then may stop or continue.
      if (!soak_on) req_b[i] = 1'b0;
      else if (!req_b[i] || s_ack_b[i]) req_b[i] = 1'($urandom_range(1, 0));
    end
    rd_b = soak_on ? ($urandom_range(3, 0) == 0) : 1'b1;
    drive();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] prev_g;
    logic [3:0] exp_seq [4];
    int nb, cnt;
    exp_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; en_a = '0; rd_a = 1'b0; rd_b = 1'b1; soak_on = 1'b0; req_b = '0;
    for (int i = 0; i < 4; i++) begin
      left_a[i] = -1;
      for (int u = 0; u < 2; u++) begin seq[u][i] = 0; rd_seq[u][i] = 0; end
    end
    drive();
    tick(); tick();
    check("rst_grant", 32'(grant_a), 32'(0));
    check("rst_busy",  32'(busy_a),  32'(0));
    check("rst_wr",    32'(fifo_wr_a), 32'(0));
    check("rst_ack",   32'(ack_a),   32'(0));
    rst_n = 1'b1;

    // Reset and first grant
    en_a = 4'b1111; rd_a = 1'b1; drive();
    tick(); check("t1_grant0", 32'(grant_a), 32'(4'b0001));
    for (int c = 0; c < 4; c++) begin tick(); check("t1_ack0", 32'(s_ack_a), 32'(4'b0001)); end
    check("t1_idle", 32'(grant_a), 32'(0));
    tick(); check("t1_grant1", 32'(grant_a), 32'(4'b0010));
    for (int c = 0; c < 4; c++) tick();
    en_a = '0; drive();
    for (int c = 0; c < 3; c++) tick();

    // Rotation and skip
    en_a = 4'b1010; drive();
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      prev_g = grant_a;
      tick();
      if (grant_a != 0 && prev_g == 0) begin
        if (nb < 4) check("t2_rot", 32'(grant_a), 32'(exp_seq[nb]));
        nb++;
      end
    end
    check("t2_bursts", 32'(nb), 32'(4));
    en_a = '0; drive();
    tick();

    // Early release
    left_a[2] = 2; en_a = 4'b1100; drive();
    tick(); check("t3_grant2", 32'(grant_a), 32'(4'b0100));
    for (int c = 0; c < 2; c++) begin tick(); check("t3_ack2", 32'(s_ack_a), 32'(4'b0100)); end
    tick(); check("t3_noack", 32'(s_ack_a), 32'(0)); check("t3_idle", 32'(grant_a), 32'(0));
    tick(); check("t3_grant3", 32'(grant_a), 32'(4'b1000));
    for (int c = 0; c < 4; c++) tick();
    en_a = '0; drive();
    for (int c = 0; c < 10; c++) tick();

    // Backpressure
    rd_a = 1'b0; left_a[0] = 7; en_a = 4'b0001; drive();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (fq_a.size() == 7 && grant_a == 0 && left_a[0] == 0) break;
    end
    check("t4_fill", 32'(fq_a.size()), 32'(7));
    en_a = 4'b0011; drive();
    tick(); check("t4_grant1", 32'(grant_a), 32'(4'b0010));
    tick(); check("t4_wr1", 32'(s_wr_a), 32'(1)); check("t4_full", 32'(fifo_full_a), 32'(1));
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_wr", 32'(s_wr_a), 32'(0));
      check("t4_hold_ack", 32'(s_ack_a), 32'(0));
    end
    rd_a = 1'b1; tick(); rd_a = 1'b0;
    check("t4_unfull", 32'(fifo_full_a), 32'(0));
    tick(); check("t4_resume", 32'(s_wr_a), 32'(1));
    rd_a = 1'b1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      cnt += int'(s_ack_a[1]);
      if (grant_a == 0) break;
    end
    check("t4_rest_of_burst", 32'(cnt), 32'(2));
    en_a = '0; drive();
    for (int c = 0; c < 12; c++) tick();

    // Reset mid-burst
    for (int i = 0; i < 4; i++) left_a[i] = -1;
    en_a = 4'b1111; drive();
    tick(); check("t5_grant2", 32'(grant_a), 32'(4'b0100));
    for (int c = 0; c < 2; c++) begin tick(); check("t5_ack", 32'(s_ack_a), 32'(4'b0100)); end
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr",    32'(fifo_wr_a), 32'(0));
    check("t5_rst_ack",   32'(ack_a),     32'(0));
    check("t5_rst_grant", 32'(grant_a),   32'(0));
    check("t5_rst_busy",  32'(busy_a),    32'(0));
    en_a = 4'b0100; drive();
    tick(); tick();
    rst_n = 1'b1;
    tick(); check("t5_regrant", 32'(grant_a), 32'(4'b0100));
    for (int c = 0; c < 4; c++) begin tick(); check("t5_burst", 32'(s_ack_a), 32'(4'b0100)); end
    check("t5_done", 32'(grant_a), 32'(0));
    en_a = '0; drive();
    for (int c = 0; c < 10; c++) tick();
    check("a_drained", 32'(fq_a.size()), 32'(0));
    for (int i = 0; i < 4; i++) check("a_all_read", 32'(rd_seq[0][i]), 32'(seq[0][i]));

    // Scoreboard soak on the 3-producer, single-word-burst arbiter
    soak_on = 1'b1;
    for (int c = 0; c < 10000; c++) tick();
    soak_on = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    check("b_drained", 32'(fq_b.size()), 32'(0));
    for (int i = 0; i < 3; i++) check("b_all_read", 32'(rd_seq[1][i]), 32'(seq[1][i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
